// File: rtl/clk_gate_pkg.sv
// Shared types and default parameters for the clock-gating enable controller.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAKE  = 2'd1,
        ST_GRANT = 2'd2,
        ST_IDLE  = 2'd3
    } state_t;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_WAKE_CYC = 2;
    localparam int DEF_IDLE_CYC = 8;

endpackage

// File: rtl/clk_gate_rr_arb.sv
// Combinational round-robin picker: lowest set request at or above the pointer,
// wrapping, found with a double-width masked priority encoder.
module clk_gate_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] win_oh_o,
    output logic [PTR_W-1:0]   win_idx_o,
    output logic               valid_o
);

    logic [NUM_REQ-1:0]   hi_mask;
    logic [2*NUM_REQ-1:0] dbl_req;
    logic                 found;

    // Lower copy keeps only bits at/above the pointer; upper copy supplies the wrap.
    always_comb begin
        hi_mask   = ~((NUM_REQ'(1) << ptr_i) - NUM_REQ'(1));
        dbl_req   = {req_i, req_i & hi_mask};
        found     = 1'b0;
        win_idx_o = '0;
        for (int i = 0; i < 2 * NUM_REQ; i++) begin
            if (!found && dbl_req[i]) begin
                found     = 1'b1;
                win_idx_o = PTR_W'(i % NUM_REQ);
            end
        end
    end

    assign valid_o  = |req_i;
    assign win_oh_o = valid_o ? (NUM_REQ'(1) << win_idx_o) : '0;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gate enable controller: wakes the gated domain on request, grants it
// round-robin, and gates it off after an idle timeout. All outputs are flops.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int WAKE_CYC = DEF_WAKE_CYC,
    parameter int IDLE_CYC = DEF_IDLE_CYC,
    parameter int CNT_W    = $clog2(((WAKE_CYC > IDLE_CYC) ? WAKE_CYC : IDLE_CYC) + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_REQ-1:0] REQ,
    input  logic               FORCE_ON,
    output logic [NUM_REQ-1:0] GNT,
    output logic               GATE_EN,
    output logic               BUSY,
    output state_t             STATE_DBG
);

    localparam int PTR_W = $clog2(NUM_REQ);

    // Handshake: REQ[i] is a level held for the whole access; GNT[i] rises once
    // the domain is awake and stays until REQ[i] is sampled low, which releases it.

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     gidx_q, gidx_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 gate_en_q;
    logic                 busy_q;

    logic [PTR_W-1:0]     arb_ptr;
    logic [NUM_REQ-1:0]   win_oh;
    logic [PTR_W-1:0]     win_idx;
    logic                 any_req;
    logic [PTR_W-1:0]     gidx_next;

    assign gidx_next = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);

    // On a handoff the search must already start past the releasing requester.
    assign arb_ptr = (state_q == ST_GRANT) ? gidx_next : ptr_q;

    clk_gate_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req_i     (REQ),
        .ptr_i     (arb_ptr),
        .win_oh_o  (win_oh),
        .win_idx_o (win_idx),
        .valid_o   (any_req)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        gnt_d   = gnt_q;
        case (state_q)
            ST_OFF: begin
                if (any_req) begin
                    state_d = ST_WAKE;
                    cnt_d   = CNT_W'(WAKE_CYC - 1);
                end
            end
            ST_WAKE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (any_req) begin
                    state_d = ST_GRANT;
                    gnt_d   = win_oh;
                    gidx_d  = win_idx;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_W'(IDLE_CYC - 1);
                end
            end
            ST_GRANT: begin
                if (!REQ[gidx_q]) begin
                    ptr_d = gidx_next;
                    if (any_req) begin
                        gnt_d  = win_oh;
                        gidx_d = win_idx;
                    end else begin
                        gnt_d   = '0;
                        state_d = ST_IDLE;
                        cnt_d   = CNT_W'(IDLE_CYC - 1);
                    end
                end
            end
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_GRANT;
                    gnt_d   = win_oh;
                    gidx_d  = win_idx;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_OFF;
                end
            end
            default: begin
                state_d = ST_OFF;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_OFF;
            cnt_q     <= '0;
            ptr_q     <= '0;
            gidx_q    <= '0;
            gnt_q     <= '0;
            gate_en_q <= FORCE_ON;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
            gnt_q     <= gnt_d;
            gate_en_q <= (state_d != ST_OFF) | FORCE_ON;
            busy_q    <= (state_d != ST_OFF);
        end
    end

    assign GNT       = gnt_q;
    assign GATE_EN   = gate_en_q;
    assign BUSY      = busy_q;
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl with NUM_REQ=4, WAKE_CYC=2, IDLE_CYC=8.
module tb_clk_gate_ctrl;
  import clk_gate_pkg::*;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic         force_on;
  logic [N-1:0] gnt;
  logic         gate_en;
  logic         busy;
  state_t       state_dbg;

  int checks = 0;
  int errors = 0;

  // expected {BUSY, GATE_EN, GNT} after the next edge
  logic [N+1:0] exp_q[$];

  clk_gate_ctrl #(
    .NUM_REQ  (N),
    .WAKE_CYC (2),
    .IDLE_CYC (8)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .REQ       (req),
    .FORCE_ON  (force_on),
    .GNT       (gnt),
    .GATE_EN   (gate_en),
    .BUSY      (busy),
    .STATE_DBG (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // driver: apply inputs, record expectation, advance one edge, compare
  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] e_gnt,
                     input logic e_gate, input logic e_busy, input string tag);
    logic [N+1:0] exp_v;
    logic [N+1:0] obs_v;
    req = r;
    exp_q.push_back({e_busy, e_gate, e_gnt});
    @(posedge clk);
    #1;
    obs_v = {busy, gate_en, gnt};
    exp_v = exp_q.pop_front();
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s: observed busy/gate/gnt=%b expected %b", tag, obs_v, exp_v);
    end
    checks++;
    assert ($onehot0(gnt)) else begin
      errors++;
      $error("FAIL %s_onehot: observed gnt=%b expected one-hot or zero", tag, gnt);
    end
  endtask

  task automatic idle_run(input string tag);
    for (int i = 0; i < 7; i++) cyc('0, '0, 1'b1, 1'b1, tag);
  endtask

  logic [N-1:0] rr_req[15];
  logic [N-1:0] rr_gnt[15];

  initial begin
    rst = 1'b1;
    force_on = 1'b0;
    req = '0;

    // reset state
    cyc('0, '0, 1'b0, 1'b0, "reset0");
    cyc('0, '0, 1'b0, 1'b0, "reset1");
    rst = 1'b0;
    cyc('0, '0, 1'b0, 1'b0, "off_quiet");

    // cold wake: enable right after the request edge, grant WAKE_CYC edges later
    cyc(4'b0100, 4'b0000, 1'b1, 1'b1, "wake_k");
    cyc(4'b0100, 4'b0000, 1'b1, 1'b1, "wake_k1");
    cyc(4'b0100, 4'b0100, 1'b1, 1'b1, "wake_gnt");
    cyc(4'b0100, 4'b0100, 1'b1, 1'b1, "wake_hold");

    // idle timeout: release, 7 more counting edges, off on the 8th
    cyc('0, '0, 1'b1, 1'b1, "idle_release");
    idle_run("idle_hold");
    cyc('0, '0, 1'b0, 1'b0, "idle_off");

    // round-robin fairness from a fresh pointer
    rst = 1'b1;
    cyc('0, '0, 1'b0, 1'b0, "rr_reset");
    rst = 1'b0;
    rr_req = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
               4'b1110, 4'b1111, 4'b1111, 4'b1101, 4'b1111,
               4'b1111, 4'b1011, 4'b1111, 4'b1111, 4'b0111};
    rr_gnt = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001,
               4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
               4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
    for (int i = 0; i < 15; i++) cyc(rr_req[i], rr_gnt[i], 1'b1, 1'b1, "rr_order");
    cyc('0, '0, 1'b1, 1'b1, "rr_release");

    // re-request on the counter==0 edge of IDLE: regrant, enable never drops
    idle_run("rereq_wait");
    cyc(4'b0001, 4'b0001, 1'b1, 1'b1, "idle_rereq");
    cyc('0, '0, 1'b1, 1'b1, "rereq_release");
    idle_run("rereq_idle");
    cyc('0, '0, 1'b0, 1'b0, "rereq_off");

    // aborted wake: request drops during wake, lands in IDLE without a grant
    cyc(4'b0010, '0, 1'b1, 1'b1, "abort_k");
    cyc('0, '0, 1'b1, 1'b1, "abort_k1");
    cyc('0, '0, 1'b1, 1'b1, "abort_k2");
    checks++;
    assert (state_dbg === ST_IDLE) else begin
      errors++;
      $error("FAIL abort_state: observed %0d expected %0d", state_dbg, ST_IDLE);
    end
    idle_run("abort_idle");
    cyc('0, '0, 1'b0, 1'b0, "abort_off");

    // reset in the middle of a grant
    cyc(4'b1000, '0, 1'b1, 1'b1, "rstmid_k");
    cyc(4'b1000, '0, 1'b1, 1'b1, "rstmid_k1");
    cyc(4'b1000, 4'b1000, 1'b1, 1'b1, "rstmid_gnt");
    rst = 1'b1;
    cyc(4'b1000, '0, 1'b0, 1'b0, "rstmid_rst");
    rst = 1'b0;
    cyc('0, '0, 1'b0, 1'b0, "rstmid_off");

    // FORCE_ON holds the enable in OFF and through reset without waking
    force_on = 1'b1;
    cyc('0, '0, 1'b1, 1'b0, "force_off0");
    cyc('0, '0, 1'b1, 1'b0, "force_off1");
    rst = 1'b1;
    cyc('0, '0, 1'b1, 1'b0, "force_rst");
    rst = 1'b0;
    force_on = 1'b0;
    cyc('0, '0, 1'b0, 1'b0, "force_release");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
